// File: rtl/apb_mult_pkg.sv
// Shared definitions for the APB multiplier sequencer.
// Holds the peripheral register word addresses, the command/status bit positions
// and the sequencer FSM state type.
package apb_mult_pkg;

    localparam logic [9:0] REG_MER   = 10'h000;
    localparam logic [9:0] REG_MCAND = 10'h001;
    localparam logic [9:0] REG_CMD   = 10'h002;
    localparam logic [9:0] REG_RES   = 10'h003;

    localparam int unsigned CMD_START = 0;
    localparam int unsigned CMD_DONE  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrMer,
        StWrMcand,
        StWrStart,
        StRdStat,
        StRdRes,
        StWrClr,
        StPush
    } state_e;

endpackage

// File: rtl/sync_fifo_w16.sv
// Synchronous 16-bit FIFO holding {mer, mcand} operand pairs.
// Ports:
//   pclk, preset      clock and synchronous active-high reset (empties the FIFO)
//   push, wdata       write request and data; ignored while full
//   pop, rdata        read request and head-of-queue data; pop ignored while empty
//   full, empty       occupancy flags
module sync_fifo_w16 #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    output logic [15:0] rdata,
    output logic        full,
    output logic        empty
);

    logic [15:0]    mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_mult_sequencer.sv
// APB2 master that drives the APB multiplier peripheral for each buffered operand pair.
// Ports:
//   pclk, preset                       clock, synchronous active-high reset
//   in_valid/in_ready/in_mer/in_mcand  signed 8-bit operand stream into the FIFO
//   out_valid/out_ready/out_product    signed 16-bit product stream
//   out_timeout                        result aborted after POLL_LIMIT status reads
//   psel/penable/pwrite/paddr/pwdata   APB request (paddr is a word address)
//   prdata                             APB read data
//   busy                               an operation is in flight or operands are queued
module apb_mult_sequencer
    import apb_mult_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_LIMIT = 300,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_mer,
    input  logic [7:0]  in_mcand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        out_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [9:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(POLL_LIMIT);

    state_e           state_q, state_d;
    logic             phase_q, phase_d;       // 0 = SETUP, 1 = ACCESS
    logic [7:0]       mer_q, mer_d, mcand_q, mcand_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [15:0]      result_q, result_d;
    logic             timeout_q, timeout_d;

    logic        fifo_full, fifo_empty, fifo_pop;
    logic [15:0] fifo_rdata;
    logic        unused_prdata;

    assign unused_prdata = ^prdata[31:16];

    sync_fifo_w16 #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .pclk   (pclk),
        .preset (preset),
        .push   (in_valid),
        .wdata  ({in_mer, in_mcand}),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign fifo_pop    = (state_q == StIdle) && !fifo_empty;
    assign out_valid   = (state_q == StPush);
    assign out_product = result_q;
    assign out_timeout = timeout_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;
    assign psel        = (state_q != StIdle) && (state_q != StPush);
    assign penable     = psel && phase_q;

    // Request fields depend only on the state, so they hold across SETUP and ACCESS.
    always_comb begin
        pwrite = 1'b0;
        paddr  = '0;
        pwdata = '0;
        unique case (state_q)
            StWrMer:   begin pwrite = 1'b1; paddr = REG_MER;   pwdata = {24'b0, mer_q};   end
            StWrMcand: begin pwrite = 1'b1; paddr = REG_MCAND; pwdata = {24'b0, mcand_q}; end
            StWrStart: begin
                pwrite = 1'b1;
                paddr  = REG_CMD;
                pwdata[CMD_START] = 1'b1;
            end
            StRdStat:  paddr = REG_CMD;
            StRdRes:   paddr = REG_RES;
            StWrClr:   begin pwrite = 1'b1; paddr = REG_CMD; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        mer_d      = mer_q;
        mcand_d    = mcand_q;
        poll_cnt_d = poll_cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    mer_d      = fifo_rdata[15:8];
                    mcand_d    = fifo_rdata[7:0];
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
                    phase_d    = 1'b0;
                    state_d    = StWrMer;
                end
            end
            StPush: begin
                if (out_ready) state_d = StIdle;
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // End of ACCESS: advance to the next transfer.
                    phase_d = 1'b0;
                    unique case (state_q)
                        StWrMer:   state_d = StWrMcand;
                        StWrMcand: state_d = StWrStart;
                        StWrStart: state_d = StRdStat;
                        StRdStat: begin
                            if (prdata[CMD_DONE]) begin
                                state_d = StRdRes;
                            end else begin
                                poll_cnt_d = poll_cnt_q + CNT_W'(1);
                                if (poll_cnt_d == POLL_MAX) begin
                                    timeout_d = 1'b1;
                                    result_d  = '0;
                                    state_d   = StWrClr;
                                end
                            end
                        end
                        StRdRes: begin
                            result_d = prdata[15:0];
                            state_d  = StWrClr;
                        end
                        StWrClr:   state_d = StPush;
                        default:   state_d = StIdle;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            mer_q      <= '0;
            mcand_q    <= '0;
            poll_cnt_q <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            mer_q      <= mer_d;
            mcand_q    <= mcand_d;
            poll_cnt_q <= poll_cnt_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_mult_sequencer.sv
// Self-checking bench for apb_mult_sequencer with a behavioural multiplier peripheral.
module tb_apb_mult_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PLIM  = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic        in_valid, in_ready;
    logic [7:0]  in_mer, in_mcand;
    logic        out_valid, out_ready, out_timeout;
    logic [15:0] out_product;
    logic        psel, penable, pwrite, busy;
    logic [9:0]  paddr;
    logic [31:0] pwdata, prdata;

    int n_checks = 0;
    int n_fail   = 0;

    apb_mult_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .POLL_LIMIT (PLIM)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mer      (in_mer),
        .in_mcand    (in_mcand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_timeout (out_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .busy        (busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return 16'(sa * sb);
    endfunction

    // ---------------- peripheral model ----------------
    logic        stall;      // peripheral never reports done
    logic [7:0]  p_mer, p_mcand;
    logic        p_start;
    logic [15:0] p_prod;
    int          p_delay;
    logic        p_done;

    assign p_done = p_start && (p_delay == 0) && !stall;

    always @(posedge pclk) begin
        if (preset) begin
            p_mer <= 0; p_mcand <= 0; p_start <= 0; p_prod <= 0; p_delay <= 0;
        end else begin
            if (p_delay > 0) p_delay <= p_delay - 1;
            if (psel && penable && pwrite) begin
                case (paddr)
                    10'h0: p_mer   <= pwdata[7:0];
                    10'h1: p_mcand <= pwdata[7:0];
                    10'h2: begin
                        p_start <= pwdata[0];
                        if (pwdata[0]) begin
                            p_prod  <= smul(p_mer, p_mcand);
                            p_delay <= int'($urandom_range(4, 0));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (paddr)
            10'h0:   prdata = {24'b0, p_mer};
            10'h1:   prdata = {24'b0, p_mcand};
            10'h2:   prdata = {30'b0, p_done, p_start};
            10'h3:   prdata = {16'b0, p_prod};
            default: prdata = 32'h0;
        endcase
    end

    // ---------------- transfer log, reference model, protocol checker ----------------
    typedef struct { logic [15:0] prod; logic to; } exp_t;
    exp_t        exp_q[$];
    logic [42:0] log_q[$];       // {write, addr, data}
    logic [15:0] got_q[$];
    logic        got_to_q[$];
    int          n_results = 0;

    logic        prev_setup = 1'b0;
    logic [9:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic        prev_write;

    always @(negedge pclk) begin
        if (preset) begin
            exp_q.delete();
            prev_setup = 1'b0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back('{prod: stall ? 16'h0 : smul(in_mer, in_mcand), to: stall});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", {out_timeout, out_product}, 64'hdead);
                end else begin
                    check("sb_product", out_product, exp_q[0].prod);
                    check("sb_timeout", out_timeout, exp_q[0].to);
                    void'(exp_q.pop_front());
                end
                got_q.push_back(out_product);
                got_to_q.push_back(out_timeout);
                n_results++;
            end
            if (psel && penable)
                log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
            if (penable)
                check("apb_access_after_setup",
                      {psel, prev_setup, paddr, pwdata, pwrite},
                      {1'b1, 1'b1, prev_addr, prev_wdata, prev_write});
            else if (psel)
                check("apb_single_setup", prev_setup, 1'b0);
            prev_setup = psel && !penable;
            prev_addr  = paddr;
            prev_wdata = pwdata;
            prev_write = pwrite;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_pair(input logic [7:0] m, input logic [7:0] c);
        bit ok = 0;
        @(posedge pclk); #1;
        in_valid = 1'b1; in_mer = m; in_mcand = c;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge pclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (n_results >= target) break;
            @(negedge pclk);
        end
        check("result_count", n_results, target);
    endtask

    function automatic logic [42:0] ent(input logic w, input logic [9:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    task automatic check_log(input logic [7:0] m, input logic [7:0] c, input logic timed_out);
        int n = log_q.size();
        int bad = 0;
        int n_stat = 0;
        check("log_length_ok", n >= 6, 1);
        if (n >= 6) begin
            check("log_wr_mer",   log_q[0], ent(1, 10'h0, {24'b0, m}));
            check("log_wr_mcand", log_q[1], ent(1, 10'h1, {24'b0, c}));
            check("log_wr_start", log_q[2], ent(1, 10'h2, 32'h1));
            check("log_wr_clr",   log_q[n-1], ent(1, 10'h2, 32'h0));
            for (int i = 3; i < n - 1; i++) begin
                if (log_q[i][42:32] == {1'b0, 10'h2}) n_stat++;
                else if (!(i == n - 2 && !timed_out && log_q[i][42:32] == {1'b0, 10'h3})) bad++;
            end
            check("log_poll_shape", bad, 0);
            if (timed_out) check("log_stat_reads", n_stat, PLIM);
            else           check("log_rd_res", log_q[n-2][42:32], {1'b0, 10'h3});
        end
    endtask

    typedef struct { logic [7:0] mer; logic [7:0] mcand; logic [15:0] prod; } vec_t;
    vec_t vecs[7];

    initial begin
        int base;
        bit ok;
        logic [7:0] bm[6], bc[6];

        vecs[0] = '{8'd3,   8'd5,   16'h000F};
        vecs[1] = '{8'hFD,  8'd5,   16'hFFF1};
        vecs[2] = '{8'h80,  8'h80,  16'h4000};
        vecs[3] = '{8'd0,   8'd7,   16'h0000};
        vecs[4] = '{8'd127, 8'h80,  16'hC080};
        vecs[5] = '{8'hFF,  8'hFF,  16'h0001};
        vecs[6] = '{8'd2,   8'd2,   16'h0004};

        preset = 1; in_valid = 0; in_mer = 0; in_mcand = 0; out_ready = 1; stall = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_out_timeout", out_timeout, 0);
        check("rst_busy", busy, 0);
        @(posedge pclk); #1 preset = 0;

        // Single operations from the vector table, with full APB sequence check.
        foreach (vecs[i]) begin
            log_q.delete();
            base = n_results;
            push_pair(vecs[i].mer, vecs[i].mcand);
            wait_results(base + 1);
            if (n_results > base) begin
                check("tbl_product", got_q[base], vecs[i].prod);
                check("tbl_timeout", got_to_q[base], 0);
            end
            check_log(vecs[i].mer, vecs[i].mcand, 1'b0);
        end
        repeat (2) @(negedge pclk);
        check("idle_busy", busy, 0);

        // Back-to-back pairs come out in push order.
        base = n_results;
        push_pair(8'hFD, 8'd5);
        push_pair(8'h80, 8'h80);
        push_pair(8'd0,  8'd7);
        wait_results(base + 3);
        if (n_results >= base + 3) begin
            check("b2b_0", got_q[base],     16'hFFF1);
            check("b2b_1", got_q[base + 1], 16'h4000);
            check("b2b_2", got_q[base + 2], 16'h0000);
        end

        // Backpressure: one pair in flight plus a full FIFO blocks the next push.
        @(posedge pclk); #1 out_ready = 0;
        base = n_results;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bm[i] = 8'($urandom); bc[i] = 8'($urandom);
        end
        for (int i = 0; i < DEPTH + 1; i++) push_pair(bm[i], bc[i]);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (out_valid) begin ok = 1; break; end
        end
        check("bp_out_valid", ok, 1);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_busy", busy, 1);
        repeat (5) @(negedge pclk);
        check("bp_no_leak", n_results, base);
        @(posedge pclk); #1 out_ready = 1;
        push_pair(bm[DEPTH + 1], bc[DEPTH + 1]);
        wait_results(base + DEPTH + 2);
        if (n_results >= base + DEPTH + 2)
            for (int i = 0; i < DEPTH + 2; i++)
                check("bp_order", got_q[base + i], smul(bm[i], bc[i]));

        // Timeout: peripheral never completes.
        stall = 1;
        log_q.delete();
        base = n_results;
        push_pair(8'd9, 8'd9);
        wait_results(base + 1);
        if (n_results > base) begin
            check("to_flag", got_to_q[base], 1);
            check("to_product", got_q[base], 0);
        end
        check_log(8'd9, 8'd9, 1'b1);

        // Reset while polling drops the operation and the queued pair.
        push_pair(8'd4, 8'd4);
        push_pair(8'd6, 8'd6);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (psel && penable && !pwrite && paddr == 10'h2) begin ok = 1; break; end
        end
        check("rs_reached_poll", ok, 1);
        @(posedge pclk); #1 preset = 1;
        @(posedge pclk);
        @(negedge pclk);
        check("rs_psel", psel, 0);
        check("rs_out_valid", out_valid, 0);
        check("rs_busy_fifo_empty", busy, 0);
        check("rs_in_ready", in_ready, 1);
        @(posedge pclk); #1 preset = 0; stall = 0;
        base = n_results;
        push_pair(8'd2, 8'd2);
        wait_results(base + 1);
        if (n_results > base) check("rs_fresh", got_q[base], 16'h0004);

        // Random traffic with random output backpressure.
        base = n_results;
        fork
            for (int i = 0; i < 20; i++) push_pair(8'($urandom), 8'($urandom));
            for (int i = 0; i < 3000; i++) begin
                if (n_results >= base + 20) break;
                @(posedge pclk); #1 out_ready = 1'($urandom_range(1, 0));
            end
        join
        @(posedge pclk); #1 out_ready = 1;
        wait_results(base + 20);
        repeat (3) @(negedge pclk);
        check("rand_model_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
